mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, so that one shared memory port and one ALU are reused across cycles.
- Supports variable-latency memory through a req/ready handshake, with a parametrised timeout, a sticky halt, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register / branch comparator and the multi-cycle datapath muxes.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before trapping; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.
- TO_W, 8, width of the wait counter; requires MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- br_taken  in  1  branch comparator result; valid in EXEC.
- instr_req  out  1  instruction fetch request.
- data_req  out  1  data memory request.
- data_we  out  1  data write (store); meaningful only with data_req.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  2  PC source: 00 = pc+4, 01 = old_pc+imm, 10 = (rs1+imm)&~1.
- alu_src  out  1  ALU B input: 0 = register, 1 = imm_gen.
- aluop  out  2  encoding to alu_control: 10 = R/I-type, 01 = branch, 00 = add.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- retired_count  out  CNT_W  count of retired instructions.
- halted  out  1  sticky; set by opcode 7'b1111111.
- error  out  1  sticky trap flag.
- err_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- state  out  3  current state, for debug.

Behaviour:
- Reset (async, while rst = 1):
  - state = FETCH, op_q = 0, wait counter = 0, retired_count = 0, halted = 0, error = 0, err_cause = 00.
  - All control outputs are 0, including instr_req.
  - instr_req rises in the first clock after rst deasserts.
  - Reset mid-access abandons the access; no write enables are asserted.
- Output style: Moore on (state, op_q). The only exceptions are ir_write, pc_write and retire, which are additionally gated by mem_ready or br_taken where listed below.
- FETCH:
  - instr_req = 1.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Latch op_q = opcode.
  - Next state is EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111.
  - Opcode 1111111 goes to HALT with no retire.
  - Any other opcode goes to ERR with err_cause = 01.
- EXEC: alu_src and aluop follow the single-cycle table (R: 0/10; I: 1/10; L/S: 1/00; B: 0/01; JAL: 0/00; JALR: 1/00).
  - B: pc_write = br_taken, pc_src = 01, retire = 1, go to FETCH.
  - JAL: pc_write = 1, pc_src = 01, go to WB.
  - JALR: pc_write = 1, pc_src = 10, go to WB.
  - L/S: go to MEM.
  - R/I: go to WB.
- MEM:
  - data_req = 1; data_we = 1 for stores.
  - On mem_ready: a load goes to WB; a store asserts retire and goes to FETCH.
- WB:
  - reg_write = 1; retire = 1; go to FETCH.
  - wb_sel = 01 for loads, 10 for JAL/JALR, 00 otherwise.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments on each non-ready cycle in those states.
  - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT - 1 with mem_ready = 0, go to ERR with err_cause = 10.
  - If mem_ready arrives on that same cycle, ready wins.
- HALT and ERR:
  - Absorbing until reset; all requests and write enables are 0.
  - halted = 1 in HALT; error = 1 in ERR.
- Latency with zero-wait memory: branch 3 cycles; R/I-type, store, JAL and JALR 4 cycles; load 5 cycles. Each memory wait cycle adds one.
- retired_count increments on each retire pulse and wraps modulo 2**CNT_W.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, ERR = 6);
  - opcode constants;
  - pc_src, wb_sel, aluop and err_cause encodings.
- One sub-module, mc_wait_timer, holds the wait counter and timeout compare (inputs: clear, count enable; output: expired).

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; reg_write = 1 only in WB with wb_sel = 00; retire pulse at cycle 4; retired_count = 1.
- lw with 3 wait cycles in FETCH and 2 in MEM -> 10 cycles total; data_req held for 3 cycles; data_we = 0; wb_sel = 01 in WB.
- beq with br_taken = 1, then again with br_taken = 0 -> pc_write = 1 with pc_src = 01 in EXEC for the first and pc_write = 0 for the second; each retires in 3 cycles.
- MEM_TIMEOUT = 4, mem_ready held at 0 in FETCH -> ERR after 4 cycles with error = 1 and err_cause = 10; mem_ready rising on the 4th cycle instead -> proceeds to DECODE, no error.
- Opcode 0001111 -> ERR with err_cause = 01; opcode 1111111 -> HALT, halted = 1, no further requests, retired_count unchanged.
- rst asserted mid-MEM of sw -> outputs 0 immediately (asynchronously); after release, FETCH with instr_req = 1 and retired_count = 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and control-field encodings for the multi-cycle control unit
package mc_ctrl_pkg;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_RI  = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR};
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory wait-cycle counter with timeout detect
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  // clear wins over counting so a fresh access always starts at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = (MEM_TIMEOUT != 0) && (cnt == TO_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM with memory handshake, timeout, halt and retire count
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32,
  parameter int TO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             instr_req,
  output logic             data_req,
  output logic             data_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       aluop,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_cause,
  output logic [2:0]       state
);
  logic [2:0] nxt;
  logic [6:0] op_q;
  logic expired, run, fetch, exec, mem, wb;
  logic is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr;
  assign run = !rst;
  assign fetch = run && state == S_FETCH;
  assign exec = run && state == S_EXEC;
  assign mem = run && state == S_MEM;
  assign wb = run && state == S_WB;
  assign is_r = op_q == OP_R;
  assign is_i = op_q == OP_I;
  assign is_l = op_q == OP_L;
  assign is_s = op_q == OP_S;
  assign is_b = op_q == OP_B;
  assign is_jal = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  // next-state selection; HALT and ERR hold until reset
  always_comb
    nxt = state == S_FETCH  ? (mem_ready ? S_DECODE : expired ? S_ERR : S_FETCH) :
          state == S_DECODE ? (op_legal(opcode) ? S_EXEC : opcode == OP_HALT ? S_HALT : S_ERR) :
          state == S_EXEC   ? (is_b ? S_FETCH : (is_l || is_s) ? S_MEM : S_WB) :
          state == S_MEM    ? (mem_ready ? (is_l ? S_WB : S_FETCH) : expired ? S_ERR : S_MEM) :
          state == S_WB     ? S_FETCH :
          (state == S_HALT || state == S_ERR) ? state : S_FETCH;
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(nxt != state),
    .en((state == S_FETCH || state == S_MEM) && !mem_ready),
    .expired(expired)
  );
  // state, latched opcode, trap cause and retire counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_FETCH;
      op_q <= '0;
      err_cause <= ERR_NONE;
      retired_count <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (nxt == S_ERR && state != S_ERR) err_cause <= state == S_DECODE ? ERR_ILL : ERR_TO;
      if (retire) retired_count <= retired_count + 1'b1;
    end
  assign instr_req = fetch;
  assign ir_write = fetch && mem_ready;
  assign pc_write = (fetch && mem_ready) || (exec && ((is_b && br_taken) || is_jal || is_jalr));
  assign pc_src = exec && (is_b || is_jal) ? PC_BR : exec && is_jalr ? PC_JR : PC_SEQ;
  assign alu_src = exec && (is_i || is_l || is_s || is_jalr);
  assign aluop = exec && (is_r || is_i) ? ALU_RI : exec && is_b ? ALU_BR : ALU_ADD;
  assign data_req = mem;
  assign data_we = mem && is_s;
  assign reg_write = wb;
  assign wb_sel = wb && is_l ? WB_MEM : wb && (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
  assign retire = (exec && is_b) || (mem && is_s && mem_ready) || wb;
  assign halted = run && state == S_HALT;
  assign error = run && state == S_ERR;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed-vector checks of the multi-cycle control unit
module tb_mc_control_unit;
  logic clk = 0, rst, mem_ready, br_taken;
  logic [6:0] opcode;
  logic instr_req, data_req, data_we, ir_write, pc_write, alu_src, reg_write, retire, halted, error;
  logic [1:0] pc_src, aluop, wb_sel, err_cause;
  logic [31:0] retired_count;
  logic [2:0] state;
  int n_chk = 0, n_pass = 0;
  int lat, n_dreq, n_we, n_pcw, n_rw, n_irw;
  logic [1:0] wbs, ex_src, ex_op, ex_pcs;
  logic [31:0] trace;
  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, HLT = 7'b1111111;

  mc_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .br_taken(br_taken),
    .instr_req(instr_req), .data_req(data_req), .data_we(data_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .aluop(aluop),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .retired_count(retired_count),
    .halted(halted), .error(error), .err_cause(err_cause), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    mem_ready = 0;
    cyc();
    rst = 0;
  endtask

  // runs one instruction from FETCH; rdy bit i drives mem_ready in cycle i+1
  task automatic run_instr(input logic [6:0] op, input logic [15:0] rdy, input logic br);
    opcode = op;
    br_taken = br;
    lat = 0; n_dreq = 0; n_we = 0; n_pcw = 0; n_rw = 0; n_irw = 0; trace = 0;
    wbs = 3; ex_src = 3; ex_op = 3; ex_pcs = 3;
    for (int i = 0; i < 20 && lat == 0; i++) begin
      mem_ready = rdy[i];
      #1;
      trace = {trace[28:0], state};
      n_dreq += int'(data_req);
      n_we += int'(data_we);
      n_pcw += int'(pc_write);
      n_rw += int'(reg_write);
      n_irw += int'(ir_write);
      if (reg_write) wbs = wb_sel;
      if (state == 3'd2) begin
        ex_src = {1'b0, alu_src};
        ex_op = aluop;
        ex_pcs = pc_src;
      end
      if (retire) lat = i + 1;
      cyc();
    end
    mem_ready = 0;
  endtask

  initial begin
    rst = 1; opcode = 0; mem_ready = 0; br_taken = 0;
    #2;
    check("rst_state", state, 0);
    check("rst_instr_req", instr_req, 0);
    check("rst_count", retired_count, 0);
    check("rst_error", error, 0);
    check("rst_halted", halted, 0);
    check("rst_cause", err_cause, 0);
    cyc();
    rst = 0;
    #1;
    check("instr_req_after_rst", instr_req, 1);

    run_instr(ADD, 16'hFFFF, 0);
    check("add_lat", lat, 4);
    check("add_trace", trace, {3'd0, 3'd1, 3'd2, 3'd4});
    check("add_regw", n_rw, 1);
    check("add_wbsel", wbs, 0);
    check("add_irw", n_irw, 1);
    check("add_alu", {ex_src, ex_op}, {2'd0, 2'b10});
    check("add_count", retired_count, 1);

    run_instr(LW, 16'h0108, 0);
    check("lw_lat", lat, 10);
    check("lw_trace", trace, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4});
    check("lw_dreq", n_dreq, 3);
    check("lw_we", n_we, 0);
    check("lw_wbsel", wbs, 1);
    check("lw_alu", {ex_src, ex_op}, {2'd1, 2'b00});
    check("lw_count", retired_count, 2);

    run_instr(BEQ, 16'hFFFF, 1);
    check("beq_t_lat", lat, 3);
    check("beq_t_trace", trace, {3'd0, 3'd1, 3'd2});
    check("beq_t_pcw", n_pcw, 2);
    check("beq_t_pcsrc", ex_pcs, 1);
    check("beq_t_alu", {ex_src, ex_op}, {2'd0, 2'b01});
    run_instr(BEQ, 16'hFFFF, 0);
    check("beq_nt_lat", lat, 3);
    check("beq_nt_pcw", n_pcw, 1);
    check("beq_count", retired_count, 4);

    run_instr(SW, 16'hFFFF, 0);
    check("sw_lat", lat, 4);
    check("sw_we", n_we, 1);
    check("sw_regw", n_rw, 0);

    run_instr(JAL, 16'hFFFF, 0);
    check("jal_lat", lat, 4);
    check("jal_wbsel", wbs, 2);
    check("jal_pcsrc", ex_pcs, 1);
    check("jal_pcw", n_pcw, 2);

    run_instr(JALR, 16'hFFFF, 0);
    check("jalr_pcsrc", ex_pcs, 2);
    check("jalr_alusrc", ex_src, 1);
    check("jalr_wbsel", wbs, 2);

    run_instr(ADDI, 16'hFFFF, 0);
    check("addi_alu", {ex_src, ex_op}, {2'd1, 2'b10});
    check("addi_wbsel", wbs, 0);
    check("mix_count", retired_count, 8);

    run_instr(ADD, 16'hFFF8, 0);
    check("ready_at_limit_lat", lat, 7);
    check("ready_at_limit_err", error, 0);
    check("ready_at_limit_count", retired_count, 9);

    mem_ready = 0;
    opcode = ADD;
    repeat (3) cyc();
    check("to_before", state, 0);
    cyc();
    check("to_state", state, 6);
    check("to_error", error, 1);
    check("to_cause", err_cause, 2);
    check("to_instr_req", instr_req, 0);
    cyc();
    check("err_absorb", state, 6);

    do_reset();
    check("rst2_count", retired_count, 0);
    check("rst2_error", error, 0);
    check("rst2_cause", err_cause, 0);

    run_instr(7'b0001111, 16'hFFFF, 0);
    check("ill_lat", lat, 0);
    check("ill_state", state, 6);
    check("ill_cause", err_cause, 1);
    check("ill_dreq", n_dreq, 0);

    do_reset();
    run_instr(ADD, 16'hFFFF, 0);
    check("pre_halt_lat", lat, 4);
    run_instr(HLT, 16'hFFFF, 0);
    check("halt_lat", lat, 0);
    check("halt_state", state, 5);
    check("halt_flag", halted, 1);
    check("halt_instr_req", instr_req, 0);
    check("halt_dreq", n_dreq, 0);
    check("halt_count", retired_count, 1);
    check("halt_error", error, 0);

    do_reset();
    run_instr(ADD, 16'hFFFF, 0);
    opcode = SW;
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    cyc();
    cyc();
    check("sw_mid_state", state, 3);
    check("sw_mid_dreq", {data_req, data_we}, 2'b11);
    #2;
    rst = 1;
    #1;
    check("async_rst_dreq", {data_req, data_we}, 2'b00);
    check("async_rst_instr_req", instr_req, 0);
    check("async_rst_state", state, 0);
    check("async_rst_count", retired_count, 0);
    cyc();
    rst = 0;
    #1;
    check("post_rst_instr_req", instr_req, 1);
    check("post_rst_state", state, 0);
    check("post_rst_count", retired_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
